// File: rtl/fde_responder_8bit.sv
// Responder for the fetch/decode/execute phase strobes. Fetches one
// instruction byte per FETCH phase over a req/ack handshake, splits it into
// opcode/operand on DECODE, and advances or loads the PC on EXECUTE. The
// sequencer enable is held low while a fetch is outstanding so memory wait
// states stall the phase rotation.
module fde_responder_8bit #(
  parameter int                 ADDR_W   = 8,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter int                 MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch,
  input  logic              decode,
  input  logic              execute,
  output logic              fde_enable,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  output logic [ADDR_W-1:0] pc,
  output logic [7:0]        ir,
  output logic [3:0]        opcode,
  output logic [3:0]        operand,
  output logic              instr_valid,
  output logic              fault
);

  typedef enum logic [1:0] {IDLE, REQ, FAULT_ST} state_t;

  state_t     state;
  state_t     state_next;
  logic       captured;
  logic [7:0] wait_cnt;
  logic       multi;
  logic       take_ack;
  logic       timeout;
  logic       active;

  // More than one strobe at once is a sequencer protocol error.
  assign multi    = (fetch & decode) | (fetch & execute) | (decode & execute);
  assign active   = (state != FAULT_ST) && !multi;
  assign take_ack = (state == REQ) && mem_ack && !multi;
  // Last allowed request cycle without ack: the next edge faults.
  assign timeout  = (state == REQ) && !mem_ack && (wait_cnt == 8'(MAX_WAIT - 1));
  assign mem_addr = pc;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic: protocol errors take priority over everything else.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (multi)                     state_next = FAULT_ST;
        else if (fetch && !captured)   state_next = REQ;
      end
      REQ: begin
        if (multi)                     state_next = FAULT_ST;
        else if (mem_ack)              state_next = IDLE;
        else if (timeout)              state_next = FAULT_ST;
      end
      default:                         state_next = FAULT_ST;
    endcase
  end

  // Output logic: stall the sequencer until this FETCH phase has its byte.
  always_comb begin
    fde_enable = (state != FAULT_ST) && !(fetch && !captured);
  end

  // Handshake control: request line, wait counter, one-read-per-phase flag, sticky fault.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req  <= 1'b0;
      wait_cnt <= '0;
      captured <= 1'b0;
      fault    <= 1'b0;
    end else begin
      mem_req  <= (state_next == REQ);
      wait_cnt <= (state == REQ && state_next == REQ) ? wait_cnt + 8'd1 : 8'd0;
      if (take_ack)                          captured <= 1'b1;
      else if (!fetch && state != FAULT_ST)  captured <= 1'b0;
      if (state_next == FAULT_ST)            fault <= 1'b1;
    end
  end

  // Instruction datapath: capture on ack, split on decode, update PC on execute.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      ir          <= '0;
      opcode      <= '0;
      operand     <= '0;
      instr_valid <= 1'b0;
    end else begin
      if (take_ack) ir <= mem_rdata;
      if (active && decode) begin
        opcode      <= ir[7:4];
        operand     <= ir[3:0];
        instr_valid <= 1'b1;
      end
      if (active && execute) begin
        pc          <= jump ? jump_target : pc + {{(ADDR_W-1){1'b0}}, 1'b1};
        instr_valid <= 1'b0;
      end
    end
  end

endmodule
